// File: rtl/zl_puncturer.sv
// DVB-S puncturer: deletes rate-1/2 encoder bits per the selected code rate and repacks survivors into I/Q pairs.
// One-cycle latency through a single output register; input stalls only while a held output is not taken.
module zl_puncturer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rate_sel,
  input  logic       data_in_i,
  input  logic       data_in_q,
  input  logic       data_in_req,
  output logic       data_in_ack,
  output logic       data_out_i,
  output logic       data_out_q,
  output logic       data_out_req,
  input  logic       data_out_ack
);

  typedef enum logic [2:0] {
    R12 = 3'd0,
    R23 = 3'd1,
    R34 = 3'd2,
    R56 = 3'd3,
    R78 = 3'd4
  } rate_t;

  rate_t      rate_q;
  rate_t      rate_eff;
  logic [2:0] phase;
  logic [2:0] phase_nxt;
  logic [2:0] period;
  logic [6:0] mask_x;
  logic [6:0] mask_y;
  logic       keep_x;
  logic       keep_y;
  logic       keep_both;
  logic       first_bit;
  logic       produce;
  logic       accept;
  logic       pend_valid;
  logic       pend_bit;
  logic       pend_valid_nxt;
  logic       pend_bit_nxt;
  logic       out_i_nxt;
  logic       out_q_nxt;

  assign data_in_ack = !data_out_req || data_out_ack;
  assign accept      = data_in_req && data_in_ack;

  // The rate is sampled only at a period start so a period is never mixed.
  always_comb begin
    rate_eff = rate_q;
    if (phase == 3'd0) begin
      case (rate_sel)
        3'd1:    rate_eff = R23;
        3'd2:    rate_eff = R34;
        3'd3:    rate_eff = R56;
        3'd4:    rate_eff = R78;
        default: rate_eff = R12;
      endcase
    end
  end

  // Masks are stored LSB = first phase of the period.
  always_comb begin
    period = 3'd1;
    mask_x = 7'b0000001;
    mask_y = 7'b0000001;
    case (rate_eff)
      R23: begin period = 3'd4; mask_x = 7'b0000101; mask_y = 7'b0001111; end
      R34: begin period = 3'd3; mask_x = 7'b0000101; mask_y = 7'b0000011; end
      R56: begin period = 3'd5; mask_x = 7'b0010101; mask_y = 7'b0001011; end
      R78: begin period = 3'd7; mask_x = 7'b1010001; mask_y = 7'b0101111; end
      default: begin period = 3'd1; mask_x = 7'b0000001; mask_y = 7'b0000001; end
    endcase
  end

  always_comb begin
    keep_x    = mask_x[phase];
    keep_y    = mask_y[phase];
    keep_both = keep_x && keep_y;
    first_bit = keep_x ? data_in_i : data_in_q;
    phase_nxt = (phase == period - 3'd1) ? 3'd0 : phase + 3'd1;
  end

  // A pending bit always leads the next pair; a single kept bit with nothing pending waits.
  always_comb begin
    produce        = pend_valid || keep_both;
    out_i_nxt      = pend_valid ? pend_bit : data_in_i;
    out_q_nxt      = pend_valid ? first_bit : data_in_q;
    pend_valid_nxt = pend_valid ? keep_both : !keep_both;
    pend_bit_nxt   = pend_valid ? data_in_q : first_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= 3'd0;
      rate_q       <= R12;
      pend_valid   <= 1'b0;
      pend_bit     <= 1'b0;
      data_out_req <= 1'b0;
      data_out_i   <= 1'b0;
      data_out_q   <= 1'b0;
    end else begin
      if (accept) begin
        phase      <= phase_nxt;
        pend_valid <= pend_valid_nxt;
        pend_bit   <= pend_bit_nxt;
        if (phase == 3'd0) begin
          rate_q <= rate_eff;
        end
      end
      if (accept && produce) begin
        data_out_req <= 1'b1;
        data_out_i   <= out_i_nxt;
        data_out_q   <= out_q_nxt;
      end else if (data_out_ack) begin
        data_out_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zl_puncturer.sv
// Bench for zl_puncturer: stream-level reference model feeding a scoreboard, plus directed scenarios.
module tb_zl_puncturer;

  typedef logic [1:0] pair_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rate_sel = 3'd0;
  logic       data_in_i = 1'b0;
  logic       data_in_q = 1'b0;
  logic       data_in_req = 1'b0;
  logic       data_in_ack;
  logic       data_out_i;
  logic       data_out_q;
  logic       data_out_req;
  logic       data_out_ack = 1'b1;

  int    errors = 0;
  int    checks = 0;
  int    n_out = 0;
  bit    rand_ack = 1'b0;
  pair_t exp_q[$];
  pair_t got_q[$];
  pair_t mon_e;
  logic  bits_q[$];
  int    m_phase = 0;
  int    m_rate = 0;

  // Puncturing matrices written phase 1..P, straight from the standard.
  string xm[5] = '{"1", "1010", "101", "10101", "1000101"};
  string ym[5] = '{"1", "1111", "110", "11010", "1111010"};

  zl_puncturer dut (
    .clk(clk), .rst_n(rst_n), .rate_sel(rate_sel),
    .data_in_i(data_in_i), .data_in_q(data_in_q), .data_in_req(data_in_req),
    .data_in_ack(data_in_ack),
    .data_out_i(data_out_i), .data_out_q(data_out_q), .data_out_req(data_out_req),
    .data_out_ack(data_out_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    exp_q.delete();
    m_phase = 0;
    m_rate  = 0;
  endtask

  // Kept bits go onto one serial stream; every two of them form an output pair.
  task automatic model_accept(logic x, logic y, logic [2:0] sel);
    int r;
    r = (m_phase == 0) ? ((sel > 3'd4) ? 0 : int'(sel)) : m_rate;
    if (m_phase == 0) m_rate = r;
    if (xm[r][m_phase] == "1") bits_q.push_back(x);
    if (ym[r][m_phase] == "1") bits_q.push_back(y);
    m_phase = (m_phase + 1) % xm[r].len();
    while (bits_q.size() >= 2) begin
      exp_q.push_back({bits_q[0], bits_q[1]});
      void'(bits_q.pop_front());
      void'(bits_q.pop_front());
    end
  endtask

  task automatic send(logic x, logic y);
    bit ok = 1'b0;
    data_in_i   = x;
    data_in_q   = y;
    data_in_req = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (data_in_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) model_accept(x, y, rate_sel);
    else chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    data_in_req = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    rand_ack = 1'b0;
    @(posedge clk);
    #2;
    data_out_ack = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !data_out_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a pair transfers on the next edge when req & ack are seen here.
  always @(negedge clk) begin
    if (rst_n && data_out_req && data_out_ack) begin
      checks++;
      n_out++;
      got_q.push_back({data_out_i, data_out_q});
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %b%b, expected no output", data_out_i, data_out_q);
      end else begin
        mon_e = exp_q.pop_front();
        if ({data_out_i, data_out_q} !== mon_e) begin
          errors++;
          $display("FAIL sb_pair: got %b%b, expected %b", data_out_i, data_out_q, mon_e);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ack) begin
      #1;
      if (rand_ack) data_out_ack = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    #12;
    chk("rst_out_req", data_out_req, 0);
    chk("rst_out_i", data_out_i, 0);
    chk("rst_out_q", data_out_q, 0);
    chk("rst_in_ack", data_in_ack, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rate 1/2: pass-through, one cycle latency, back-to-back.
    got_q.delete();
    rate_sel = 3'd0;
    send(1'b1, 1'b0);
    chk("r12_latency_req", data_out_req, 1);
    chk("r12_latency_dat", {data_out_i, data_out_q}, 2'b10);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    drain();
    chk("r12_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("r12_p0", got_q[0], 2'b10);
      chk("r12_p1", got_q[1], 2'b01);
      chk("r12_p2", got_q[2], 2'b11);
    end

    // Rate 3/4.
    got_q.delete();
    rate_sel = 3'd2;
    send(1'b1, 1'b0);
    chk("r34_first_out", data_out_req, 1);
    send(1'b0, 1'b1);
    chk("r34_pend_only", data_out_req, 0);
    send(1'b1, 1'b1);
    drain();
    chk("r34_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("r34_p0", got_q[0], 2'b10);
      chk("r34_p1", got_q[1], 2'b11);
    end

    // Rate 7/8, two periods of (1,0).
    got_q.delete();
    rate_sel = 3'd4;
    repeat (14) send(1'b1, 1'b0);
    drain();
    chk("r78_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        pair_t e;
        case (i % 4)
          0:       e = 2'b10;
          1:       e = 2'b00;
          default: e = 2'b01;
        endcase
        chk($sformatf("r78_p%0d", i), got_q[i], e);
      end
    end

    // Rate 2/3 random data with random downstream stalls.
    rate_sel = 3'd1;
    n0 = n_out;
    rand_ack = 1'b1;
    for (int i = 0; i < 400; i++) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    chk("r23_count", n_out - n0, 300);

    // Backpressure at rate 1/2.
    got_q.delete();
    rate_sel = 3'd0;
    data_out_ack = 1'b0;
    send(1'b1, 1'b0);
    fork
      send(1'b0, 1'b1);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("bp_req", data_out_req, 1);
          chk("bp_dat", {data_out_i, data_out_q}, 2'b10);
          chk("bp_in_ack", data_in_ack, 0);
        end
        @(posedge clk);
        #1;
        data_out_ack = 1'b1;
      end
    join
    drain();
    chk("bp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_p0", got_q[0], 2'b10);
      chk("bp_p1", got_q[1], 2'b01);
    end

    // Rate change mid-period only applies at the next period.
    got_q.delete();
    rate_sel = 3'd2;
    send(1'b1, 1'b1);
    rate_sel = 3'd0;
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    drain();
    chk("rc_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("rc_p1", got_q[1], 2'b11);
      chk("rc_p3", got_q[3], 2'b00);
    end

    // Reset mid-period with a held output and a bit pending before it.
    rate_sel = 3'd4;
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    data_out_ack = 1'b0;
    send(1'b1, 1'b1);
    chk("mid_held", data_out_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", data_out_req, 0);
    chk("mid_rst_in_ack", data_in_ack, 1);
    model_reset();
    got_q.delete();
    data_out_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rate_sel = 3'd2;
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    drain();
    chk("post_rst_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("post_rst_p0", got_q[0], 2'b10);
      chk("post_rst_p1", got_q[1], 2'b11);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
